inst_fetch_unit: RTL and testbench

- Front-end stage of the multi-cycle RV32I core. Owns the program counter, fetches one instruction word per instruction through a req/ack instruction-memory port, and holds it stable on `inst` for the control FSM.
- The control FSM pulses `fetch_start` in its FETCH state. It pulses `pc_advance` at the end of WRITEBACK, with an optional branch/jump redirect.
- Misaligned redirects and memory timeouts are detected here.

---
 rtl/inst_fetch_unit.sv | 126 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit for the multi-cycle RV32I core.
// Owns the PC, issues one req/ack read per instruction, holds the fetched
// word for the control FSM and flags misaligned redirects and ack timeouts.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_advance,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_err,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [31:0] PC_INIT     = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic        merr_q, merr_d;
  logic        ferr_q, ferr_d;

  assign cnt_inc = cnt_q + 8'd1;

  // State, PC, instruction latch, timeout counter and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= PC_INIT;
      inst_q  <= NOP_INST;
      cnt_q   <= '0;
      merr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      merr_q  <= merr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: fetch handshake, timeout detection and PC update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    merr_d  = merr_q;
    ferr_d  = ferr_q;
    unique case (state_q)
      S_IDLE: begin
        if (fetch_start) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // An ack in the final allowed cycle still completes the fetch.
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = S_VALID;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) begin
            ferr_d  = 1'b1;
            state_d = S_ERROR;
          end
        end
      end
      S_VALID: begin
        // pc_advance has priority; a concurrent fetch_start is dropped.
        if (pc_advance) begin
          state_d = S_IDLE;
          if (!pc_load) begin
            pc_d = pc_q + 32'd4;
          end else if (pc_target[1:0] == 2'b00) begin
            pc_d = pc_target;
          end else begin
            merr_d  = 1'b1;
            state_d = S_ERROR;
          end
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_req     = (state_q == S_WAIT);
  assign imem_addr    = pc_q;
  assign inst         = inst_q;
  assign inst_valid   = (state_q == S_VALID);
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign misalign_err = merr_q;
  assign fetch_err    = ferr_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed test-plan steps followed by random
// stimulus, every cycle compared against a behavioural reference model.
module tb_inst_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, fetch_start, pc_advance, pc_load, imem_ack;
  logic [31:0] pc_target, imem_rdata;
  logic        imem_req, inst_valid, misalign_err, fetch_err;
  logic [31:0] imem_addr, inst, pc, pc_plus4;

  logic        w_reset, w_fetch_start, w_pc_advance, w_pc_load, w_imem_ack;
  logic [31:0] w_pc_target, w_imem_rdata;
  logic        w_imem_req, w_inst_valid, w_misalign_err, w_fetch_err;
  logic [31:0] w_imem_addr, w_inst, w_pc, w_pc_plus4;

  inst_fetch_unit dut (
    .clk(clk), .reset(reset), .fetch_start(fetch_start),
    .pc_advance(pc_advance), .pc_load(pc_load), .pc_target(pc_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .inst(inst), .inst_valid(inst_valid), .pc(pc),
    .pc_plus4(pc_plus4), .misalign_err(misalign_err), .fetch_err(fetch_err)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(3)) dut_w (
    .clk(clk), .reset(w_reset), .fetch_start(w_fetch_start),
    .pc_advance(w_pc_advance), .pc_load(w_pc_load), .pc_target(w_pc_target),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .imem_ack(w_imem_ack), .inst(w_inst), .inst_valid(w_inst_valid), .pc(w_pc),
    .pc_plus4(w_pc_plus4), .misalign_err(w_misalign_err), .fetch_err(w_fetch_err)
  );

  // Reference model of the default-parameter DUT
  logic [31:0] m_pc, m_inst;
  logic        m_waiting, m_valid, m_dead, m_merr, m_ferr;
  int          m_elapsed;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_edge();
    if (reset) begin
      m_pc = 32'h0; m_inst = 32'h0000_0013;
      m_waiting = 0; m_valid = 0; m_dead = 0; m_merr = 0; m_ferr = 0;
      m_elapsed = 0;
    end else if (m_dead) begin
      // everything ignored until reset
    end else if (m_waiting) begin
      if (imem_ack) begin
        m_inst = imem_rdata; m_valid = 1; m_waiting = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == 16) begin
          m_ferr = 1; m_dead = 1; m_waiting = 0;
        end
      end
    end else if (m_valid) begin
      if (pc_advance) begin
        m_valid = 0;
        if (!pc_load) m_pc = m_pc + 32'd4;
        else if (pc_target % 4 == 0) m_pc = pc_target;
        else begin m_merr = 1; m_dead = 1; end
      end
    end else if (fetch_start) begin
      m_waiting = 1; m_elapsed = 0;
    end
  endtask

  task automatic check_model();
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("inst", inst, m_inst);
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_waiting});
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_merr});
    chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_ferr});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic clr();
    reset = 0; fetch_start = 0; pc_advance = 0; pc_load = 0; imem_ack = 0;
    pc_target = '0; imem_rdata = '0;
    w_reset = 0; w_fetch_start = 0; w_pc_advance = 0; w_pc_load = 0;
    w_imem_ack = 0; w_pc_target = '0; w_imem_rdata = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    reset = 1; w_reset = 1;
    step();
    clr();
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);

    // Sequential fetch, ack in the third WAIT cycle
    fetch_start = 1; step(); fetch_start = 0;
    chk("seq_req", {31'd0, imem_req}, 32'd1);
    step(); step();
    imem_ack = 1; imem_rdata = 32'h0050_0093; step(); imem_ack = 0;
    chk("seq1_inst", inst, 32'h0050_0093);
    chk("seq1_pc", pc, 32'h0);
    chk("seq1_valid", {31'd0, inst_valid}, 32'd1);
    pc_advance = 1; step(); pc_advance = 0;
    chk("seq_between_valid", {31'd0, inst_valid}, 32'd0);
    chk("seq_adv_pc", pc, 32'h4);
    fetch_start = 1; step(); fetch_start = 0;
    step(); step();
    imem_ack = 1; imem_rdata = 32'h0010_0113; step(); imem_ack = 0;
    chk("seq2_inst", inst, 32'h0010_0113);
    chk("seq2_pc", pc, 32'h4);
    chk("seq2_pc_plus4", pc_plus4, 32'h8);

    // fetch_start while VALID is ignored
    fetch_start = 1; step(); fetch_start = 0;
    chk("valid_fetch_ign_req", {31'd0, imem_req}, 32'd0);
    chk("valid_fetch_ign_valid", {31'd0, inst_valid}, 32'd1);

    // pc_advance while IDLE is ignored
    pc_advance = 1; step();
    pc_load = 1; pc_target = 32'h100; step(); clr();
    chk("idle_adv_ign_pc", pc, 32'h8);

    // Same-cycle ack: valid two edges after fetch_start
    fetch_start = 1; step(); fetch_start = 0;
    imem_ack = 1; imem_rdata = 32'h0000_0063; step(); imem_ack = 0;
    chk("fast_valid", {31'd0, inst_valid}, 32'd1);

    // Branch redirect with concurrent fetch_start (dropped)
    pc_advance = 1; pc_load = 1; pc_target = 32'h40; fetch_start = 1; step(); clr();
    chk("br_pc", pc, 32'h40);
    chk("br_req_dropped", {31'd0, imem_req}, 32'd0);
    fetch_start = 1; step(); fetch_start = 0;
    chk("br_req", {31'd0, imem_req}, 32'd1);
    chk("br_addr", imem_addr, 32'h40);
    imem_ack = 1; imem_rdata = $urandom; step(); imem_ack = 0;

    // Misaligned redirect
    pc_advance = 1; pc_load = 1; pc_target = 32'h42; step(); clr();
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_pc", pc, 32'h40);
    fetch_start = 1; step(); fetch_start = 0;
    chk("mis_req", {31'd0, imem_req}, 32'd0);
    reset = 1; step(); reset = 0;
    chk("mis_rst_err", {31'd0, misalign_err}, 32'd0);
    chk("mis_rst_pc", pc, 32'h0);

    // Timeout: error exactly 16 cycles after WAIT entry
    fetch_start = 1; step(); fetch_start = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 15) begin
        chk("to_15_req", {31'd0, imem_req}, 32'd1);
        chk("to_15_err", {31'd0, fetch_err}, 32'd0);
      end
    end
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; step(); imem_ack = 0;
    chk("to_late_ack_inst", inst, 32'h0000_0013);
    reset = 1; step(); reset = 0;

    // Reset in WAIT followed by a stale ack
    fetch_start = 1; step(); fetch_start = 0; step();
    reset = 1; step(); reset = 0;
    chk("rw_req_at_reset", {31'd0, imem_req}, 32'd0);
    imem_ack = 1; imem_rdata = 32'hCAFE_F00D; step(); imem_ack = 0;
    chk("rw_req", {31'd0, imem_req}, 32'd0);
    chk("rw_inst", inst, 32'h0000_0013);
    chk("rw_valid", {31'd0, inst_valid}, 32'd0);
    chk("rw_pc", pc, 32'h0);

    // Second instance: PC wrap and short timeout
    chk("w_rst_pc", w_pc, 32'hFFFF_FFFC);
    chk("w_rst_plus4", w_pc_plus4, 32'h0);
    w_fetch_start = 1; step(); w_fetch_start = 0;
    w_imem_ack = 1; w_imem_rdata = 32'h0000_0013; step(); w_imem_ack = 0;
    chk("w_valid", {31'd0, w_inst_valid}, 32'd1);
    w_pc_advance = 1; step(); w_pc_advance = 0;
    chk("w_wrap_pc", w_pc, 32'h0);
    chk("w_wrap_merr", {31'd0, w_misalign_err}, 32'd0);
    w_fetch_start = 1; step(); w_fetch_start = 0;
    step(); step();
    chk("w_to_req_before", {31'd0, w_imem_req}, 32'd1);
    chk("w_to_err_before", {31'd0, w_fetch_err}, 32'd0);
    step();
    chk("w_to_err", {31'd0, w_fetch_err}, 32'd1);
    chk("w_to_req", {31'd0, w_imem_req}, 32'd0);

    // Random stimulus against the model
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 59) == 0);
      fetch_start = ($urandom_range(0, 2) == 0);
      pc_advance  = ($urandom_range(0, 2) == 0);
      pc_load     = $urandom_range(0, 1);
      pc_target   = $urandom;
      if ($urandom_range(0, 7) != 0) pc_target[1:0] = 2'b00;
      imem_ack    = ($urandom_range(0, 3) == 0);
      imem_rdata  = $urandom;
      step();
    end
    clr();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
